// File: rtl/add_arbiter_pkg.sv
// Shared types and helpers for the add_arbiter block and its round-robin picker.
package add_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 16;

   // Requester index width; a single requester still needs one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/add_arbiter_if.sv
// Request/operand bus and response channel of the shared adder.
interface add_arbiter_if
   import add_arbiter_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
);
   localparam int IDW = id_width(NREQ);

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_in;
   logic [NREQ*WIDTH-1:0] b_in;
   logic [NREQ-1:0]       gnt;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_sum;
   logic                  rsp_carry;
   logic                  busy;

   modport master (
      output req, a_in, b_in, rsp_ready,
      input  gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
   );

   modport slave (
      input  req, a_in, b_in, rsp_ready,
      output gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
   );

endinterface

// File: rtl/add_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping.
module rr_pick
   import add_arbiter_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDW  = id_width(NREQ)
)(
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_win,
   output logic [IDW-1:0]  o_win_id,
   output logic            o_any
);

   int w_idx;

   always_comb begin
      o_win    = '0;
      o_win_id = '0;
      o_any    = 1'b0;
      w_idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = (int'(i_ptr) + k) % NREQ;
         if (!o_any && (((i_req >> w_idx) & NREQ'(1)) != '0)) begin
            o_any    = 1'b1;
            o_win    = NREQ'(1) << w_idx;
            o_win_id = IDW'(w_idx);
         end
      end
   end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin shared registered adder: one operation in flight, result returned
// with requester id and carry over a valid/ready channel.
module add_arbiter
   import add_arbiter_pkg::*;
#(
   parameter int NREQ    = DEF_NREQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int ADD_LAT = 1
)(
   input  logic          clk,
   input  logic          rst,
   add_arbiter_if.slave  bus
);

   localparam int IDW  = id_width(NREQ);
   localparam int CNTW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

   logic [WIDTH-1:0] w_a_arr [NREQ];
   logic [WIDTH-1:0] w_b_arr [NREQ];
   logic [NREQ-1:0]  w_win;
   logic [IDW-1:0]   w_win_id;
   logic             w_any;

   state_t           r_state;
   logic [IDW-1:0]   r_ptr;
   logic [CNTW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IDW-1:0]   r_id;
   logic [NREQ-1:0]  r_gnt;
   logic             r_valid;
   logic [IDW-1:0]   r_rsp_id;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_busy;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
         assign w_a_arr[gi] = bus.a_in[gi*WIDTH +: WIDTH];
         assign w_b_arr[gi] = bus.b_in[gi*WIDTH +: WIDTH];
      end
   endgenerate

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .i_req    (bus.req),
      .i_ptr    (r_ptr),
      .o_win    (w_win),
      .o_win_id (w_win_id),
      .o_any    (w_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_ptr    <= '0;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_id     <= '0;
         r_gnt    <= '0;
         r_valid  <= 1'b0;
         r_rsp_id <= '0;
         r_sum    <= '0;
         r_carry  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_a     <= w_a_arr[w_win_id];
                  r_b     <= w_b_arr[w_win_id];
                  r_id    <= w_win_id;
                  r_gnt   <= w_win;
                  r_ptr   <= (w_win_id == IDW'(NREQ-1)) ? '0 : w_win_id + 1'b1;
                  r_cnt   <= CNTW'(ADD_LAT-1);
                  r_busy  <= 1'b1;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_gnt <= '0;
               if (r_cnt == '0) begin
                  {r_carry, r_sum} <= {1'b0, r_a} + {1'b0, r_b};
                  r_rsp_id         <= r_id;
                  r_valid          <= 1'b1;
                  r_state          <= DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DONE: begin
               // Response data stays put after the handshake; only valid drops.
               if (bus.rsp_ready) begin
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.rsp_valid = r_valid;
   assign bus.rsp_id    = r_rsp_id;
   assign bus.rsp_sum   = r_sum;
   assign bus.rsp_carry = r_carry;
   assign bus.busy      = r_busy;

endmodule
